// File: rtl/sfx_event_sequencer.sv
// Turns level-type collision flags into prioritised, frame-timed effect enables for the APU.
// One effect plays at a time; higher priority preempts, lower priority queues behind a gap.
module sfx_event_sequencer #(
    parameter int CNT_W      = 6,
    parameter int DUR_SHEEP  = 8,
    parameter int DUR_SWORD  = 4,
    parameter int DUR_PLAYER = 16,
    parameter int GAP_FRAMES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end,
    input  logic       sheep_hit,
    input  logic       sword_hit,
    input  logic       player_hit,
    output logic       SheepDragonCollision,
    output logic       SwordDragonCollision,
    output logic       PlayerDragonCollision,
    output logic       busy,
    output logic [1:0] active_id
);

    if (DUR_SHEEP >= 2**CNT_W || DUR_SWORD >= 2**CNT_W ||
        DUR_PLAYER >= 2**CNT_W || GAP_FRAMES >= 2**CNT_W) begin : g_width_err
        $error("sfx_event_sequencer: a duration or GAP_FRAMES does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] D_SHEEP  = CNT_W'((DUR_SHEEP  == 0) ? 1 : DUR_SHEEP);
    localparam logic [CNT_W-1:0] D_SWORD  = CNT_W'((DUR_SWORD  == 0) ? 1 : DUR_SWORD);
    localparam logic [CNT_W-1:0] D_PLAYER = CNT_W'((DUR_PLAYER == 0) ? 1 : DUR_PLAYER);
    localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_FRAMES);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [2:0]       pend, nxt_pend;
    logic [2:0]       hist;
    logic             armed;
    logic [1:0]       nxt_id;
    logic [2:0]       raw, ev, merged;
    logic [1:0]       t_ev, t_pm;

    // Request vectors are {player, sword, sheep}; id 3 is the highest priority.
    function automatic logic [1:0] top_id(input logic [2:0] v);
        if (v[2])      return 2'd3;
        else if (v[1]) return 2'd2;
        else if (v[0]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [2:0] id_mask(input logic [1:0] id);
        case (id)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] dur_of(input logic [1:0] id);
        case (id)
            2'd1:    return D_SHEEP;
            2'd2:    return D_SWORD;
            default: return D_PLAYER;
        endcase
    endfunction

    // armed stays low for the first edge after reset so a held level cannot fire
    always_comb begin
        raw       = {player_hit, sword_hit, sheep_hit};
        ev        = armed ? (raw & ~hist) : 3'b000;
        merged    = pend | ev;
        t_ev      = top_id(ev);
        t_pm      = top_id(merged);
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_pend  = pend;
        nxt_id    = active_id;
        case (state)
            IDLE: begin
                if (t_ev != 2'd0) begin
                    nxt_state = PLAY;
                    nxt_id    = t_ev;
                    nxt_cnt   = dur_of(t_ev);
                    nxt_pend  = merged & ~id_mask(t_ev);
                end
            end
            PLAY: begin
                nxt_pend = merged;
                if (t_ev != 2'd0 && t_ev >= active_id) begin
                    nxt_id   = t_ev;
                    nxt_cnt  = dur_of(t_ev);
                    nxt_pend = merged & ~id_mask(t_ev);
                end else if (frame_end) begin
                    if (cnt > ONE) begin
                        nxt_cnt = cnt - ONE;
                    end else if (GAP_FRAMES != 0) begin
                        nxt_state = GAP;
                        nxt_cnt   = GAP_CNT;
                        nxt_id    = 2'd0;
                    end else if (t_pm != 2'd0) begin
                        nxt_id   = t_pm;
                        nxt_cnt  = dur_of(t_pm);
                        nxt_pend = merged & ~id_mask(t_pm);
                    end else begin
                        nxt_state = IDLE;
                        nxt_cnt   = '0;
                        nxt_id    = 2'd0;
                    end
                end
            end
            GAP: begin
                nxt_pend = merged;
                if (frame_end) begin
                    if (cnt > ONE) begin
                        nxt_cnt = cnt - ONE;
                    end else if (t_pm != 2'd0) begin
                        nxt_state = PLAY;
                        nxt_id    = t_pm;
                        nxt_cnt   = dur_of(t_pm);
                        nxt_pend  = merged & ~id_mask(t_pm);
                    end else begin
                        nxt_state = IDLE;
                        nxt_cnt   = '0;
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
                nxt_pend  = 3'b000;
                nxt_id    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            cnt                   <= '0;
            pend                  <= 3'b000;
            hist                  <= 3'b000;
            armed                 <= 1'b0;
            active_id             <= 2'd0;
            busy                  <= 1'b0;
            SheepDragonCollision  <= 1'b0;
            SwordDragonCollision  <= 1'b0;
            PlayerDragonCollision <= 1'b0;
        end else begin
            state                 <= nxt_state;
            cnt                   <= nxt_cnt;
            pend                  <= nxt_pend;
            hist                  <= raw;
            armed                 <= 1'b1;
            active_id             <= nxt_id;
            busy                  <= (nxt_state != IDLE);
            SheepDragonCollision  <= (nxt_id == 2'd1);
            SwordDragonCollision  <= (nxt_id == 2'd2);
            PlayerDragonCollision <= (nxt_id == 2'd3);
        end
    end

endmodule
